// File: rtl/mips_mc_core.sv
// Multicycle MIPS subset core: lw, sw, add/sub/and/or/slt, addi, beq, j.
// One instruction is walked through a short state sequence. Fetches and data
// accesses share a single memory port, which is held until mem_ready.
module mips_mc_core #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          ADDR_W          = 32,
  parameter bit          TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic              halted,
  output logic [31:0]       pc_dbg
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    RTEX, RTWB, ADDIEX, ADDIWB, BRANCH, JUMP, TRAP
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t      stateReg, stateNext;
  logic [31:0] pcReg, irReg, aReg, bReg, aluOutReg, mdrReg;
  logic [31:0] regFile [0:31];

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] sextImm;
  logic [31:0] aluResult;
  logic [31:0] addrSel;
  logic        memReqRaw;
  logic        accept;
  logic        wrEn;
  logic [4:0]  wrAddr;
  logic [31:0] wrData;

  assign opcode  = irReg[31:26];
  assign rs      = irReg[25:21];
  assign rt      = irReg[20:16];
  assign rd      = irReg[15:11];
  assign funct   = irReg[5:0];
  assign sextImm = {{16{irReg[15]}}, irReg[15:0]};

  // Reset gates the request combinationally so an access pending when reset
  // arrives can never complete in the reset cycle.
  assign mem_req   = memReqRaw & rst_n;
  assign accept    = mem_req & mem_ready;
  assign mem_addr  = addrSel[ADDR_W-1:0];
  assign mem_wdata = bReg;
  assign pc_dbg    = pcReg;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) stateReg <= FETCH;
    else        stateReg <= stateNext;
  end

  // Next-state logic: memory states wait for acceptance, others take one cycle
  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      FETCH:  if (accept) stateNext = DECODE;
      DECODE: begin
        case (opcode)
          OP_RTYPE:     stateNext = RTEX;
          OP_LW, OP_SW: stateNext = MEMADR;
          OP_ADDI:      stateNext = ADDIEX;
          OP_BEQ:       stateNext = BRANCH;
          OP_J:         stateNext = JUMP;
          default:      stateNext = TRAP_ON_ILLEGAL ? TRAP : FETCH;
        endcase
      end
      MEMADR: stateNext = (opcode == OP_LW) ? MEMRD : MEMWR;
      MEMRD:  if (accept) stateNext = MEMWB;
      MEMWR:  if (accept) stateNext = FETCH;
      RTEX:   stateNext = RTWB;
      ADDIEX: stateNext = ADDIWB;
      TRAP:   stateNext = TRAP;
      default: stateNext = FETCH;   // MEMWB, RTWB, ADDIWB, BRANCH, JUMP
    endcase
  end

  // Output decode: memory port control and halt flag
  always_comb begin
    memReqRaw = 1'b0;
    mem_we    = 1'b0;
    addrSel   = aluOutReg;
    halted    = 1'b0;
    case (stateReg)
      FETCH: begin
        memReqRaw = 1'b1;
        addrSel   = pcReg;
      end
      MEMRD: memReqRaw = 1'b1;
      MEMWR: begin
        memReqRaw = 1'b1;
        mem_we    = 1'b1;
      end
      TRAP:  halted = 1'b1;
      default: ;
    endcase
  end

  // ALU for R-type; unknown funct codes produce zero
  always_comb begin
    aluResult = 32'd0;
    case (funct)
      6'b100000: aluResult = aReg + bReg;
      6'b100010: aluResult = aReg - bReg;
      6'b100100: aluResult = aReg & bReg;
      6'b100101: aluResult = aReg | bReg;
      6'b101010: aluResult = {31'd0, $signed(aReg) < $signed(bReg)};
      default:   aluResult = 32'd0;
    endcase
  end

  // Register-file write port selection for the three write-back states
  always_comb begin
    wrEn   = 1'b0;
    wrAddr = rt;
    wrData = aluOutReg;
    case (stateReg)
      MEMWB: begin
        wrEn   = 1'b1;
        wrData = mdrReg;
      end
      RTWB: begin
        wrEn   = 1'b1;
        wrAddr = rd;
      end
      ADDIWB: wrEn = 1'b1;
      default: ;
    endcase
  end

  // Register file; r0 is never written so it always reads as zero
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regFile[i] <= 32'd0;
    end else if (wrEn && (wrAddr != 5'd0)) begin
      regFile[wrAddr] <= wrData;
    end
  end

  // Datapath registers: PC, IR, A, B, ALUOut, MDR
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pcReg     <= RESET_PC;
      irReg     <= 32'd0;
      aReg      <= 32'd0;
      bReg      <= 32'd0;
      aluOutReg <= 32'd0;
      mdrReg    <= 32'd0;
    end else begin
      case (stateReg)
        FETCH: if (accept) begin
          irReg <= mem_rdata;
          pcReg <= pcReg + 32'd4;
        end
        DECODE: begin
          aReg      <= regFile[rs];
          bReg      <= regFile[rt];
          // Branch target computed speculatively while the opcode is decoded
          aluOutReg <= pcReg + (sextImm << 2);
        end
        MEMADR, ADDIEX: aluOutReg <= aReg + sextImm;
        MEMRD:  if (accept) mdrReg <= mem_rdata;
        RTEX:   aluOutReg <= aluResult;
        BRANCH: if (aReg == bReg) pcReg <= aluOutReg;
        JUMP:   pcReg <= {pcReg[31:28], irReg[25:0], 2'b00};
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_mc_core.sv
// Scoreboard bench for mips_mc_core. Two instances: dut0 traps on illegal
// opcodes from reset address 0, dut1 treats them as NOP from 0x3000_0000.
// Every accepted memory access is compared against a queued expectation
// carrying direction, address, store data and the cycle since reset release.
module tb_mips_mc_core;

  localparam logic [31:0] ILL = 32'hFC00_0000;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] cyc;
  } txn_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0, rst1;
  logic        req0, we0, ready0, halted0;
  logic        req1, we1, ready1, halted1;
  logic [31:0] addr0, wdata0, rdata0, pcDbg0;
  logic [31:0] addr1, wdata1, rdata1, pcDbg1;
  logic [31:0] mem0 [0:255];
  logic [31:0] mem1 [0:255];
  logic [31:0] cyc0 = 32'd0, cyc1 = 32'd0;
  logic [31:0] stallLo0 = 32'd0, stallHi0 = 32'd0;

  txn_t q0[$];
  txn_t q1[$];
  int   checks = 0;
  int   errors = 0;

  mips_mc_core #(.RESET_PC(32'h0000_0000), .ADDR_W(32), .TRAP_ON_ILLEGAL(1'b1)) dut0 (
    .clk(clk), .rst_n(rst0), .mem_req(req0), .mem_we(we0), .mem_addr(addr0),
    .mem_wdata(wdata0), .mem_rdata(rdata0), .mem_ready(ready0),
    .halted(halted0), .pc_dbg(pcDbg0)
  );

  mips_mc_core #(.RESET_PC(32'h3000_0000), .ADDR_W(32), .TRAP_ON_ILLEGAL(1'b0)) dut1 (
    .clk(clk), .rst_n(rst1), .mem_req(req1), .mem_we(we1), .mem_addr(addr1),
    .mem_wdata(wdata1), .mem_rdata(rdata1), .mem_ready(ready1),
    .halted(halted1), .pc_dbg(pcDbg1)
  );

  // Read-only memory models; stores are observed only through the scoreboard
  assign rdata0 = mem0[addr0[9:2]];
  assign rdata1 = mem1[addr1[9:2]];
  assign ready0 = !((cyc0 >= stallLo0) && (cyc0 <= stallHi0));
  assign ready1 = 1'b1;

  // Cycle 1 is the first cycle after the last reset edge
  always @(posedge clk) begin
    cyc0 <= !rst0 ? 32'd1 : cyc0 + 32'd1;
    cyc1 <= !rst1 ? 32'd1 : cyc1 + 32'd1;
  end

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'b000000, rs, rt, rd, 5'd0, fn};
  endfunction

  task automatic pushExp(input int d, input logic we, input logic [31:0] addr,
                         input logic [31:0] data, input logic [31:0] cyc);
    txn_t t;
    t.we = we; t.addr = addr; t.data = data; t.cyc = cyc;
    if (d == 0) q0.push_back(t);
    else        q1.push_back(t);
  endtask

  task automatic checkTxn(input int d, input txn_t e, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] cyc);
    checks++;
    if ((we !== e.we) || (addr !== e.addr) || (cyc !== e.cyc) || (e.we && (wdata !== e.data))) begin
      errors++;
      $display("FAIL dut%0d access: got we=%0b addr=%h data=%h cyc=%0d, expected we=%0b addr=%h data=%h cyc=%0d",
               d, we, addr, wdata, cyc, e.we, e.addr, e.data, e.cyc);
    end else begin
      $display("dut%0d %s addr=%h data=%h cyc=%0d ok", d, we ? "write" : "read ", addr, wdata, cyc);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Monitors: pop and compare on every accepted access
  always @(negedge clk) begin
    if (req0 && ready0) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut0 unexpected access: we=%0b addr=%h cyc=%0d", we0, addr0, cyc0);
      end else begin
        checkTxn(0, q0.pop_front(), we0, addr0, wdata0, cyc0);
      end
    end
  end

  always @(negedge clk) begin
    if (req1 && ready1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut1 unexpected access: we=%0b addr=%h cyc=%0d", we1, addr1, cyc1);
      end else begin
        checkTxn(1, q1.pop_front(), we1, addr1, wdata1, cyc1);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic waitDrain(input int d, input int budget);
    int k = 0;
    while (((d == 0) ? q0.size() : q1.size()) != 0 && k < budget) begin
      @(posedge clk); #1; k++;
    end
    chk($sformatf("dut%0d pending accesses", d), (d == 0) ? q0.size() : q1.size(), 32'd0);
    if (d == 0) q0.delete();
    else        q1.delete();
  endtask

  // Put dut0 into reset, verify reset outputs, clear its memory
  task automatic startDut0();
    rst0 = 1'b0;
    stallLo0 = 32'd0; stallHi0 = 32'd0;
    @(posedge clk); #1;
    chk("dut0 reset mem_req", {31'd0, req0}, 32'd0);
    chk("dut0 reset halted", {31'd0, halted0}, 32'd0);
    chk("dut0 reset pc_dbg", pcDbg0, 32'h0000_0000);
    for (int i = 0; i < 256; i++) mem0[i] = ILL;
  endtask

  task automatic finishTrap0(input logic [31:0] pcExp);
    waitDrain(0, 200);
    idle(6);
    chk("dut0 halted", {31'd0, halted0}, 32'd1);
    chk("dut0 trap pc", pcDbg0, pcExp);
    chk("dut0 trap mem_req", {31'd0, req0}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] t;
    int k;
    rst0 = 1'b0;
    rst1 = 1'b0;
    for (int i = 0; i < 256; i++) mem1[i] = ILL;
    idle(2);

    // addi/addi/add/sw: store of 12 to 0x10 in cycle 16, then trap at 0x10
    startDut0();
    mem0[0] = itype(6'b001000, 5'd0, 5'd1, 16'd5);
    mem0[1] = itype(6'b001000, 5'd0, 5'd2, 16'd7);
    mem0[2] = rtype(5'd1, 5'd2, 5'd3, 6'b100000);
    mem0[3] = itype(6'b101011, 5'd0, 5'd3, 16'h0010);
    pushExp(0, 0, 32'h00, 0, 1);
    pushExp(0, 0, 32'h04, 0, 5);
    pushExp(0, 0, 32'h08, 0, 9);
    pushExp(0, 0, 32'h0C, 0, 13);
    pushExp(0, 1, 32'h10, 32'd12, 16);
    pushExp(0, 0, 32'h10, 0, 17);
    rst0 = 1'b1;
    finishTrap0(32'h14);

    // j to 0x100, lw with three wait cycles (8-cycle instruction), sw r4
    startDut0();
    mem0[0]  = {6'b000010, 26'h40};
    mem0[4]  = 32'd12;
    mem0[64] = itype(6'b100011, 5'd0, 5'd4, 16'h0010);
    mem0[65] = itype(6'b101011, 5'd0, 5'd4, 16'h0020);
    stallLo0 = 32'd7; stallHi0 = 32'd9;
    pushExp(0, 0, 32'h000, 0, 1);
    pushExp(0, 0, 32'h100, 0, 4);
    pushExp(0, 0, 32'h010, 0, 10);
    pushExp(0, 0, 32'h104, 0, 12);
    pushExp(0, 1, 32'h020, 32'd12, 15);
    pushExp(0, 0, 32'h108, 0, 16);
    rst0 = 1'b1;
    finishTrap0(32'h10C);

    // beq r1,r1,-1 at 0x20 refetches 0x20 every 3 cycles
    startDut0();
    mem0[0] = itype(6'b001000, 5'd0, 5'd1, 16'd3);
    mem0[1] = {6'b000010, 26'h8};
    mem0[8] = itype(6'b000100, 5'd1, 5'd1, 16'hFFFF);
    pushExp(0, 0, 32'h00, 0, 1);
    pushExp(0, 0, 32'h04, 0, 5);
    pushExp(0, 0, 32'h20, 0, 8);
    pushExp(0, 0, 32'h20, 0, 11);
    pushExp(0, 0, 32'h20, 0, 14);
    pushExp(0, 0, 32'h20, 0, 17);
    rst0 = 1'b1;
    waitDrain(0, 200);

    // beq r1,r2,-1 with r1 != r2 falls through to 0x24
    startDut0();
    mem0[0] = itype(6'b001000, 5'd0, 5'd1, 16'd3);
    mem0[1] = {6'b000010, 26'h8};
    mem0[8] = itype(6'b000100, 5'd1, 5'd2, 16'hFFFF);
    pushExp(0, 0, 32'h00, 0, 1);
    pushExp(0, 0, 32'h04, 0, 5);
    pushExp(0, 0, 32'h20, 0, 8);
    pushExp(0, 0, 32'h24, 0, 11);
    rst0 = 1'b1;
    finishTrap0(32'h28);

    // addi r0,r0,9 is discarded: sw r0 stores 0
    startDut0();
    mem0[0] = itype(6'b001000, 5'd0, 5'd0, 16'd9);
    mem0[1] = itype(6'b101011, 5'd0, 5'd0, 16'h0030);
    pushExp(0, 0, 32'h00, 0, 1);
    pushExp(0, 0, 32'h04, 0, 5);
    pushExp(0, 1, 32'h30, 32'd0, 8);
    pushExp(0, 0, 32'h08, 0, 9);
    rst0 = 1'b1;
    finishTrap0(32'h0C);

    // ALU ops with r1=5, r2=-3: sub 8, and 5, or -3, slt 1 / 0, bad funct 0
    startDut0();
    mem0[0]  = itype(6'b001000, 5'd0, 5'd1, 16'd5);
    mem0[1]  = itype(6'b001000, 5'd0, 5'd2, 16'hFFFD);
    mem0[2]  = rtype(5'd1, 5'd2, 5'd3, 6'b100010);
    mem0[3]  = rtype(5'd1, 5'd2, 5'd4, 6'b100100);
    mem0[4]  = rtype(5'd1, 5'd2, 5'd5, 6'b100101);
    mem0[5]  = rtype(5'd2, 5'd1, 5'd6, 6'b101010);
    mem0[6]  = rtype(5'd1, 5'd2, 5'd7, 6'b101010);
    mem0[7]  = rtype(5'd1, 5'd2, 5'd1, 6'b000110);
    mem0[8]  = itype(6'b101011, 5'd0, 5'd3, 16'h0080);
    mem0[9]  = itype(6'b101011, 5'd0, 5'd4, 16'h0084);
    mem0[10] = itype(6'b101011, 5'd0, 5'd5, 16'h0088);
    mem0[11] = itype(6'b101011, 5'd0, 5'd6, 16'h008C);
    mem0[12] = itype(6'b101011, 5'd0, 5'd7, 16'h0090);
    mem0[13] = itype(6'b101011, 5'd0, 5'd1, 16'h0094);
    t = 32'd1;
    for (int i = 0; i < 8; i++) begin
      pushExp(0, 0, 32'(4 * i), 0, t);
      t = t + 32'd4;
    end
    pushExp(0, 0, 32'h20, 0, t); pushExp(0, 1, 32'h80, 32'd8,         t + 3); t = t + 4;
    pushExp(0, 0, 32'h24, 0, t); pushExp(0, 1, 32'h84, 32'd5,         t + 3); t = t + 4;
    pushExp(0, 0, 32'h28, 0, t); pushExp(0, 1, 32'h88, 32'hFFFF_FFFD, t + 3); t = t + 4;
    pushExp(0, 0, 32'h2C, 0, t); pushExp(0, 1, 32'h8C, 32'd1,         t + 3); t = t + 4;
    pushExp(0, 0, 32'h30, 0, t); pushExp(0, 1, 32'h90, 32'd0,         t + 3); t = t + 4;
    pushExp(0, 0, 32'h34, 0, t); pushExp(0, 1, 32'h94, 32'd0,         t + 3); t = t + 4;
    pushExp(0, 0, 32'h38, 0, t);
    rst0 = 1'b1;
    finishTrap0(32'h3C);

    // Reset during a stalled sw, with mem_ready high in the reset cycle
    startDut0();
    mem0[0] = itype(6'b001000, 5'd0, 5'd1, 16'd5);
    mem0[1] = itype(6'b101011, 5'd0, 5'd1, 16'h0040);
    stallLo0 = 32'd8; stallHi0 = 32'd9;
    pushExp(0, 0, 32'h00, 0, 1);
    pushExp(0, 0, 32'h04, 0, 5);
    rst0 = 1'b1;
    k = 0;
    while (cyc0 != 32'd10 && k < 50) begin @(posedge clk); #1; k++; end
    chk("dut0 reached stalled store", cyc0, 32'd10);
    rst0 = 1'b0;
    #1;
    chk("dut0 mem_req in reset cycle", {31'd0, req0}, 32'd0);
    @(posedge clk); #1;
    chk("dut0 pc after mid-store reset", pcDbg0, 32'h0000_0000);
    stallLo0 = 32'd0; stallHi0 = 32'd0;
    pushExp(0, 0, 32'h00, 0, 1);
    pushExp(0, 0, 32'h04, 0, 5);
    pushExp(0, 1, 32'h40, 32'd5, 8);
    pushExp(0, 0, 32'h08, 0, 9);
    rst0 = 1'b1;
    finishTrap0(32'h0C);

    // dut1: j keeps PC[31:28]; illegal opcode runs as NOP
    chk("dut1 reset mem_req", {31'd0, req1}, 32'd0);
    chk("dut1 reset halted", {31'd0, halted1}, 32'd0);
    chk("dut1 reset pc_dbg", pcDbg1, 32'h3000_0000);
    mem1[0]  = {6'b000010, 26'h40};
    mem1[65] = itype(6'b101011, 5'd0, 5'd0, 16'h0050);
    pushExp(1, 0, 32'h3000_0000, 0, 1);
    pushExp(1, 0, 32'h3000_0100, 0, 4);
    pushExp(1, 0, 32'h3000_0104, 0, 6);
    pushExp(1, 1, 32'h0000_0050, 32'd0, 9);
    pushExp(1, 0, 32'h3000_0108, 0, 10);
    rst1 = 1'b1;
    waitDrain(1, 200);
    chk("dut1 not halted on illegal", {31'd0, halted1}, 32'd0);
    rst1 = 1'b0;
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
